// File: rtl/acc16_flag_unit_pkg.sv
// Shared types for the flag-producing accumulator: FSM state encoding,
// default data width and the registered flag bundle.
package acc16_flag_unit_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic p;
    logic o;
  } flags_t;

endpackage

// File: rtl/acc16_flag_unit_add16_flags.sv
// Combinational add stage: modular sum plus carry-out and signed overflow
// for a single step.
module add16_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};
  // Overflow: like-signed operands produced a result of the other sign.
  assign ovf = (~a[WIDTH-1] & ~b[WIDTH-1] &  sum[WIDTH-1]) |
               ( a[WIDTH-1] &  b[WIDTH-1] & ~sum[WIDTH-1]);

endmodule

// File: rtl/acc16_flag_unit.sv
// Streams len operands into an accumulator and presents one flag-qualified
// result per job over a valid/ready handshake.
module acc16_flag_unit
  import acc16_flag_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_s,
  output logic             out_z,
  output logic             out_c,
  output logic             out_p,
  output logic             out_o,
  output logic             busy
);

  state_t           state, nstate;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic             c_st, o_st;
  flags_t           fl;

  logic [WIDTH-1:0] sum;
  logic             cout, ovf;
  logic             fire, last;

  add16_flags #(.WIDTH(WIDTH)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (sum),
    .cout(cout),
    .ovf (ovf)
  );

  assign fire = (state == ACC) && in_valid;
  assign last = fire && (remaining == CNT_W'(1));

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = (len != '0) ? ACC : DONE;
      ACC:     if (last) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nstate;
      in_ready  <= (nstate == ACC);
      out_valid <= (nstate == DONE);
      busy      <= (nstate != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      c_st      <= 1'b0;
      o_st      <= 1'b0;
      out_sum   <= '0;
      fl        <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc       <= '0;
        remaining <= len;
        c_st      <= 1'b0;
        o_st      <= 1'b0;
        if (len == '0) begin
          out_sum <= '0;
          fl      <= '{s: 1'b0, z: 1'b1, c: 1'b0, p: 1'b0, o: 1'b0};
        end
      end
      if (fire) begin
        acc       <= sum;
        remaining <= remaining - 1'b1;
        c_st      <= c_st | cout;
        o_st      <= o_st | ovf;
      end
      // Result is captured on the final beat, so it is ready the next cycle.
      if (last) begin
        out_sum <= sum;
        fl      <= '{s: sum[WIDTH-1], z: (sum == '0), c: c_st | cout,
                     p: ^sum, o: o_st | ovf};
      end
    end
  end

  assign out_s = fl.s;
  assign out_z = fl.z;
  assign out_c = fl.c;
  assign out_p = fl.p;
  assign out_o = fl.o;

endmodule

// File: tb/tb_acc16_flag_unit.sv
// Randomized and directed checks of acc16_flag_unit against an arithmetic
// reference model of the job result.
module tb_acc16_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_s, out_z, out_c, out_p, out_o;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  logic [15:0] ops[$];

  acc16_flag_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_s(out_s), .out_z(out_z), .out_c(out_c), .out_p(out_p), .out_o(out_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the operand list.
  task automatic model(output logic [15:0] esum, output logic [4:0] eflg);
    int s = 0;
    bit c = 0, o = 0;
    foreach (ops[i]) begin
      int a_s = (s >= 32768) ? s - 65536 : s;
      int b_s = (ops[i] >= 16'h8000) ? int'(ops[i]) - 65536 : int'(ops[i]);
      int t = s + int'(ops[i]);
      if (t > 65535) c = 1;
      if (a_s + b_s > 32767 || a_s + b_s < -32768) o = 1;
      s = t % 65536;
    end
    esum = 16'(s);
    eflg = {esum[15], (esum == 16'h0), c, ^esum, o};
  endtask

  // mode: 0 = in_valid always high, 1 = toggle, 2 = random gaps
  task automatic run_job(input string tag, input int mode, input int hold, input bit poke_start);
    logic [15:0] esum;
    logic [4:0]  eflg;
    int idx = 0, cyc = 0;
    bit v;
    model(esum, eflg);
    @(negedge clk);
    start = 1'b1; len = 8'(ops.size());
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    while (idx < ops.size() && cyc < 1000) begin
      chk({tag, ".in_ready"}, in_ready, 1);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? ops[idx] : 16'($urandom);
      start    = poke_start && (cyc == 0);
      len      = 8'd7;
      cyc++;
      @(negedge clk);
      if (v) idx++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk({tag, ".beats"}, idx, ops.size());
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".in_ready_done"}, in_ready, 0);
    chk({tag, ".sum"}, out_sum, esum);
    chk({tag, ".flags"}, {out_s, out_z, out_c, out_p, out_o}, eflg);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, ".hold"}, {out_valid, out_sum, out_s, out_z, out_c, out_p, out_o},
          {1'b1, esum, eflg});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".released"}, {out_valid, busy, in_ready}, 3'b000);
  endtask

  initial begin
    #12;
    chk("reset", {out_valid, in_ready, busy, out_sum, out_s, out_z, out_c, out_p, out_o}, '0);
    rst_n = 1'b1;

    ops = '{16'h0001, 16'h0002};         run_job("add", 0, 0, 0);
    ops = '{16'hFFFF, 16'h0001};         run_job("carry", 0, 0, 0);
    ops = '{16'h7FFF, 16'h0001};         run_job("ovf", 0, 0, 0);
    ops = '{16'h8000, 16'h8000, 16'h0005}; run_job("sticky", 0, 0, 0);
    ops = '{16'h0001, 16'h0001, 16'h0001, 16'h0001}; run_job("toggle", 1, 0, 0);
    ops = '{16'h1234, 16'h0F0F};         run_job("stall_out", 0, 5, 0);
    ops = '{16'h0010, 16'h0020, 16'h0030}; run_job("start_in_acc", 0, 0, 1);
    ops = {};                            run_job("len0", 0, 1, 0);

    // reset mid-job
    @(negedge clk);
    start = 1'b1; len = 8'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 16'h4444;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset", {out_valid, in_ready, busy, out_sum, out_s, out_z, out_c, out_p, out_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, in_ready}, 2'b00);
    ops = '{16'h0003};                   run_job("fresh", 0, 0, 0);

    for (int j = 0; j < 25; j++) begin
      ops = {};
      for (int k = 0; k < $urandom_range(1, 12); k++) ops.push_back(16'($urandom));
      run_job("rand", 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
